// File: rtl/ifetch_queue.sv
// Purpose : instruction fetch engine plus small in-order instruction queue with redirect flush.
// Latency : o_mem_req at cycle T, i_mem_rvalid at T+1 -> o_instr_valid at T+2 (empty queue).
// Backpressure: i_instr_ready=0 lets the queue fill; no new read is issued while it is full.
//
// Ports:
//   i_clk, i_rst_n              clock (rising edge), async active-low reset
//   i_redirect, i_redirect_pc   branch/jump redirect strobe and target
//   o_mem_req, o_mem_addr       single-cycle read request to instruction memory
//   i_mem_rvalid, i_mem_rdata   read response (one outstanding read at most)
//   o_instr_valid, o_instr,     queue head: valid flag, instruction word and its address
//   o_instr_pc, i_instr_ready   consumer accepts the head when valid & ready
module ifetch_queue #(
  parameter int                    ADDR_WIDTH = 14,
  parameter int                    DATA_WIDTH = 16,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 14'h2000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_redirect,
  input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
  output logic                  o_mem_req,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic                  i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_instr_valid,
  output logic [DATA_WIDTH-1:0] o_instr,
  output logic [ADDR_WIDTH-1:0] o_instr_pc,
  input  logic                  i_instr_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    KILL  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [CW-1:0]         r_count;
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_q_dat [DEPTH];
  logic [ADDR_WIDTH-1:0] r_q_pc  [DEPTH];

  logic w_mem_req;
  logic w_push;
  logic w_pop;

  // A redirect suppresses the request, the push and the pop in the same cycle.
  assign w_mem_req = (r_state == FETCH) && (r_count < DEPTH_C) && !i_redirect;
  assign w_push    = (r_state == WAIT) && i_mem_rvalid && !i_redirect;
  assign w_pop     = (r_count != '0) && i_instr_ready && !i_redirect;

  assign o_mem_req     = w_mem_req;
  assign o_mem_addr    = r_fetch_pc;
  assign o_instr_valid = (r_count != '0);
  assign o_instr       = r_q_dat[r_rd_ptr];
  assign o_instr_pc    = r_q_pc[r_rd_ptr];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FETCH: begin
        // rvalid is deliberately ignored here: no read of ours is outstanding.
        if (w_mem_req) w_state_nxt = WAIT;
      end
      WAIT: begin
        if (i_mem_rvalid)    w_state_nxt = FETCH;  // data pushed or, on redirect, dropped
        else if (i_redirect) w_state_nxt = KILL;   // stale response still in flight
      end
      KILL: begin
        // The stale response retires the outstanding read even if a new
        // redirect lands on the same cycle; otherwise we would wait forever.
        if (i_mem_rvalid) w_state_nxt = FETCH;
      end
      default: w_state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= FETCH;
      r_fetch_pc <= RESET_PC;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (i_redirect) begin
        r_fetch_pc <= i_redirect_pc;
        r_count    <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
      end else begin
        if (w_push) begin
          r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(1);  // wraps naturally at 2^ADDR_WIDTH
          r_wr_ptr   <= r_wr_ptr + PW'(1);
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Queue storage needs no reset: contents are qualified by r_count.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_q_dat[r_wr_ptr] <= i_mem_rdata;
      r_q_pc[r_wr_ptr]  <= r_fetch_pc;
    end
  end

endmodule
